// File: rtl/pia_fifo_6502_if.sv
// ----------------------------------------------------------------------------
// pia_fifo_6502_if
//
// Purpose: bundles the CPU register bus and the UART byte handshake of the
// buffered Apple 1 keyboard/display adapter.
//
// Signals:
//   reg_sel  [1:0]  register select: 0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR
//   rd              one-cycle read strobe for the selected register
//   wr              one-cycle write strobe for the selected register
//   din      [7:0]  CPU write data
//   dout     [7:0]  read data, combinational from reg_sel and adapter state
//   rx_data  [7:0]  UART received byte
//   rx_flag         UART has a byte
//   rx_ack          one-cycle pulse, UART consumes its byte
//   tx_data  [7:0]  byte presented to the UART
//   tx_flag         UART transmitter ready
//   tx_wr           one-cycle pulse, UART starts sending tx_data
//
// Modports:
//   master  CPU decode + UART side (drives strobes, data and UART flags)
//   slave   the adapter itself
// ----------------------------------------------------------------------------
interface pia_fifo_6502_if;
    logic [1:0] reg_sel;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_flag;
    logic       tx_wr;

    modport master (
        output reg_sel, rd, wr, din, rx_data, rx_flag, tx_flag,
        input  dout, rx_ack, tx_data, tx_wr
    );

    modport slave (
        input  reg_sel, rd, wr, din, rx_data, rx_flag, tx_flag,
        output dout, rx_ack, tx_data, tx_wr
    );
endinterface

// File: rtl/pia_fifo_6502.sv
// ----------------------------------------------------------------------------
// pia_fifo_6502
//
// Purpose: buffered Apple 1 keyboard/display adapter between the 6502 bus
// decode and the UART. A keyboard (RX) FIFO collects UART bytes and a display
// (TX) FIFO queues CPU writes for the UART. Presents the PIA-style registers
// KBD, KBDCR, DSP and DSPCR.
//
// Ports:
//   eclk    emulation clock, all state updates on its rising edge
//   ereset  asynchronous, active-high reset
//   bus     pia_fifo_6502_if.slave: register bus + UART handshake
//
// Parameters:
//   RX_DEPTH_LOG2  log2 of keyboard FIFO depth (1..8)
//   TX_DEPTH_LOG2  log2 of display FIFO depth (1..8)
//   TX_GUARD       cycles after tx_wr during which tx_flag is ignored (>= 1)
//
// Build option:
//   PIA_FIFO_UPCASE_EN  when defined, received a-z are stored as A-Z.
// ----------------------------------------------------------------------------
module pia_fifo_6502 #(
    parameter int unsigned RX_DEPTH_LOG2 = 4,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned TX_GUARD      = 2
) (
    input  logic                  eclk,
    input  logic                  ereset,
    pia_fifo_6502_if.slave        bus
);

    localparam int unsigned RxDepth = 1 << RX_DEPTH_LOG2;
    localparam int unsigned TxDepth = 1 << TX_DEPTH_LOG2;
    localparam int unsigned RxCntW  = RX_DEPTH_LOG2 + 1;
    localparam int unsigned TxCntW  = TX_DEPTH_LOG2 + 1;
    localparam int unsigned GuardW  = $clog2(TX_GUARD + 1);

    localparam logic [RxCntW-1:0] RxFullCnt = RxCntW'(RxDepth);
    localparam logic [TxCntW-1:0] TxFullCnt = TxCntW'(TxDepth);
    localparam logic [GuardW-1:0] GuardInit = GuardW'(TX_GUARD);

    localparam logic [1:0] SelKbd   = 2'd0;
    localparam logic [1:0] SelKbdcr = 2'd1;
    localparam logic [1:0] SelDsp   = 2'd2;
    localparam logic [1:0] SelDspcr = 2'd3;

    typedef enum logic {
        RxIdle,
        RxHold
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxLoad,
        TxBusy
    } tx_state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    rx_state_e                rx_state_q, rx_state_d;
    logic [RX_DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d;
    logic [RX_DEPTH_LOG2-1:0] rx_rptr_q, rx_rptr_d;
    logic [RxCntW-1:0]        rx_count_q, rx_count_d;

    tx_state_e                tx_state_q, tx_state_d;
    logic [TX_DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d;
    logic [TX_DEPTH_LOG2-1:0] tx_rptr_q, tx_rptr_d;
    logic [TxCntW-1:0]        tx_count_q, tx_count_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_wr_q, tx_wr_d;
    logic [GuardW-1:0]        guard_q, guard_d;
    logic                     tx_ovf_q, tx_ovf_d;
    logic [6:0]               dsp_last_q, dsp_last_d;

    logic [6:0] rx_mem [RxDepth];
    logic [6:0] tx_mem [TxDepth];

    // ------------------------------------------------------------------------
    // Decode and FIFO control
    // ------------------------------------------------------------------------
    logic       rx_empty, rx_full, rx_push, rx_pop;
    logic       tx_empty, tx_full, tx_push, tx_pop;
    logic       kbd_rd, dspcr_rd, dsp_wr;
    logic [6:0] rx_push_data;
    logic [6:0] rx_head, tx_head;
    logic [8:0] tx_count_ext;
    logic [5:0] tx_count_sat;
    logic       unused_rx_msb;

    // Bit 7 of the received byte is never stored.
    assign unused_rx_msb = bus.rx_data[7];

    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == RxFullCnt);
    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == TxFullCnt);

    assign rx_head = rx_mem[rx_rptr_q];
    assign tx_head = tx_mem[tx_rptr_q];

    assign kbd_rd   = bus.rd && (bus.reg_sel == SelKbd);
    assign dspcr_rd = bus.rd && (bus.reg_sel == SelDspcr);
    assign dsp_wr   = bus.wr && (bus.reg_sel == SelDsp);

    // Ack is issued in the same cycle the byte is pushed; a full FIFO leaves
    // the byte waiting in the UART.
    assign rx_push = (rx_state_q == RxIdle) && bus.rx_flag && !rx_full;
    assign rx_pop  = kbd_rd && !rx_empty;
    assign tx_push = dsp_wr && !tx_full;
    assign tx_pop  = (tx_state_q == TxIdle) && !tx_empty && bus.tx_flag;

    always_comb begin
        rx_push_data = bus.rx_data[6:0];
`ifdef PIA_FIFO_UPCASE_EN
        if ((bus.rx_data[6:0] >= 7'h61) && (bus.rx_data[6:0] <= 7'h7a)) begin
            rx_push_data = bus.rx_data[6:0] - 7'h20;
        end
`endif
    end

    // Count field in DSPCR is only six bits wide; deeper FIFOs saturate.
    assign tx_count_ext = 9'(tx_count_q);
    assign tx_count_sat = (tx_count_ext > 9'd63) ? 6'd63 : tx_count_ext[5:0];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // RX FIFO
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_push) begin
            rx_wptr_d = rx_wptr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + 1'b1;
        end
        unique case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase

        // RX FSM: wait for the UART to drop its flag before accepting again.
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RxIdle:  if (rx_push) rx_state_d = RxHold;
            RxHold:  if (!bus.rx_flag) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase

        // TX FIFO
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push) begin
            tx_wptr_d = tx_wptr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + 1'b1;
        end
        unique case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase

        // DSP register side effects; a same-cycle overflow beats the clear.
        dsp_last_d = dsp_last_q;
        if (dsp_wr) begin
            dsp_last_d = bus.din[6:0];
        end
        tx_ovf_d = tx_ovf_q;
        if (dspcr_rd) begin
            tx_ovf_d = 1'b0;
        end
        if (dsp_wr && tx_full) begin
            tx_ovf_d = 1'b1;
        end

        // TX FSM: tx_wr is high exactly while in TxLoad.
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        guard_d    = guard_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_pop) begin
                    tx_state_d = TxLoad;
                    tx_data_d  = {1'b0, tx_head};
                    tx_wr_d    = 1'b1;
                end
            end
            TxLoad: begin
                tx_state_d = TxBusy;
                guard_d    = GuardInit;
            end
            TxBusy: begin
                // The UART may still show ready right after tx_wr; ignore it
                // until the guard has expired.
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (bus.tx_flag) begin
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            rx_state_q <= RxIdle;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_state_q <= TxIdle;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            tx_data_q  <= 8'h00;
            tx_wr_q    <= 1'b0;
            guard_q    <= '0;
            tx_ovf_q   <= 1'b0;
            dsp_last_q <= 7'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_state_q <= tx_state_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            guard_q    <= guard_d;
            tx_ovf_q   <= tx_ovf_d;
            dsp_last_q <= dsp_last_d;
        end
    end

    // FIFO storage needs no reset; pointers and counts define validity.
    always_ff @(posedge eclk) begin
        if (rx_push) begin
            rx_mem[rx_wptr_q] <= rx_push_data;
        end
        if (tx_push) begin
            tx_mem[tx_wptr_q] <= bus.din[6:0];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.rx_ack  = rx_push;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;

    always_comb begin
        bus.dout = 8'h00;
        unique case (bus.reg_sel)
            SelKbd:   bus.dout = rx_empty ? 8'h80 : {1'b1, rx_head};
            SelKbdcr: bus.dout = {!rx_empty, 7'd0};
            SelDsp:   bus.dout = {tx_full, dsp_last_q};
            SelDspcr: bus.dout = {tx_empty, tx_ovf_q, tx_count_sat};
            default:  bus.dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_pia_fifo_6502.sv
`timescale 1ns/1ps
module tb_pia_fifo_6502;

    localparam int unsigned TxGuard = 2;
    localparam logic [1:0] SelKbd   = 2'd0;
    localparam logic [1:0] SelKbdcr = 2'd1;
    localparam logic [1:0] SelDsp   = 2'd2;
    localparam logic [1:0] SelDspcr = 2'd3;

    logic eclk = 1'b0;
    logic ereset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    pia_fifo_6502_if bus ();

    pia_fifo_6502 #(
        .RX_DEPTH_LOG2(4),
        .TX_DEPTH_LOG2(4),
        .TX_GUARD     (TxGuard)
    ) dut (
        .eclk  (eclk),
        .ereset(ereset),
        .bus   (bus)
    );

    always #5 eclk = ~eclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

    // Drivers: all start and end at posedge+1.
    task automatic cpu_read(input logic [1:0] sel, output logic [7:0] val);
        bus.reg_sel = sel;
        bus.rd = 1'b1;
        #1 val = bus.dout;
        @(posedge eclk);
        #1 bus.rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] sel, input logic [7:0] data);
        bus.reg_sel = sel;
        bus.din = data;
        bus.wr = 1'b1;
        @(posedge eclk);
        #1 bus.wr = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 if (bus.rx_ack) ok = 1'b1;
            @(posedge eclk);
            #1;
        end
        bus.rx_flag = 1'b0;
        @(posedge eclk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        bit seen;
        bus.reg_sel = SelKbd;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.din = 8'h00;
        bus.rx_data = 8'h00;
        bus.rx_flag = 1'b0;
        bus.tx_flag = 1'b0;
        ereset = 1'b1;
        repeat (3) @(posedge eclk);
        #1 ereset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 if (bus.rx_ack || bus.tx_wr) seen = 1'b1;
            @(posedge eclk);
            #1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL reset_strobes: rx_ack/tx_wr pulsed, want none");
        else pass_cnt++;
        total_cnt++;
        if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data);
        else pass_cnt++;
        cpu_read(SelKbdcr, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL reset_kbdcr: got %h want 00", v);
        else pass_cnt++;
        cpu_read(SelDspcr, v);
        total_cnt++;
        if (v !== 8'h80) $display("FAIL reset_dspcr: got %h want 80", v);
        else pass_cnt++;
        cpu_read(SelKbd, v);
        total_cnt++;
        if (v !== 8'h80) $display("FAIL reset_kbd: got %h want 80", v);
        else pass_cnt++;
        cpu_read(SelDsp, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL reset_dsp: got %h want 00", v);
        else pass_cnt++;
    endtask

    task automatic test_rx_basic();
        logic [7:0] v;
        bit ok;
        // First byte by hand to pin down the ack-to-KBDCR latency.
        bus.rx_data = 8'h41;
        bus.rx_flag = 1'b1;
        bus.reg_sel = SelKbdcr;
        #1;
        total_cnt++;
        if (bus.rx_ack !== 1'b1 || bus.dout !== 8'h00)
            $display("FAIL rx_ack_cycle: ack=%b kbdcr=%h want ack=1 kbdcr=00",
                     bus.rx_ack, bus.dout);
        else pass_cnt++;
        @(posedge eclk);
        #1 bus.rx_flag = 1'b0;
        #1;
        total_cnt++;
        if (bus.dout !== 8'h80 || bus.rx_ack !== 1'b0)
            $display("FAIL rx_latency: kbdcr=%h ack=%b want kbdcr=80 ack=0",
                     bus.dout, bus.rx_ack);
        else pass_cnt++;
        @(posedge eclk);
        #1;
        uart_send(8'h0d, ok);
        total_cnt++;
        if (!ok) $display("FAIL rx_send_0d: no rx_ack within budget");
        else pass_cnt++;
        cpu_read(SelKbd, v);
        total_cnt++;
        if (v !== 8'hC1) $display("FAIL rx_kbd_first: got %h want C1", v);
        else pass_cnt++;
        cpu_read(SelKbd, v);
        total_cnt++;
        if (v !== 8'h8D) $display("FAIL rx_kbd_second: got %h want 8D", v);
        else pass_cnt++;
        cpu_read(SelKbdcr, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL rx_kbdcr_empty: got %h want 00", v);
        else pass_cnt++;
        cpu_read(SelKbd, v);
        total_cnt++;
        if (v !== 8'h80) $display("FAIL rx_kbd_empty: got %h want 80", v);
        else pass_cnt++;
    endtask

    task automatic test_tx_overflow();
        logic [7:0] v;
        bus.tx_flag = 1'b0;
        for (int i = 0; i < 17; i++) cpu_write(SelDsp, 8'(8'h30 + i));
        cpu_read(SelDsp, v);
        total_cnt++;
        if (v !== 8'hC0) $display("FAIL tx_dsp_busy: got %h want C0", v);
        else pass_cnt++;
        cpu_read(SelDspcr, v);
        total_cnt++;
        if (v !== 8'h50) $display("FAIL tx_dspcr_ovf: got %h want 50", v);
        else pass_cnt++;
        cpu_read(SelDspcr, v);
        total_cnt++;
        if (v !== 8'h10) $display("FAIL tx_dspcr_cleared: got %h want 10", v);
        else pass_cnt++;
    endtask

    task automatic test_tx_drain();
        logic [7:0] v;
        int n, last, min_gap, gap;
        n = 0;
        last = -1;
        min_gap = 1000;
        bus.tx_flag = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (bus.tx_wr) begin
                if (last >= 0) begin
                    gap = cyc - last - 1;
                    if (gap < min_gap) min_gap = gap;
                end
                last = cyc;
                if (n < 16) begin
                    total_cnt++;
                    if (bus.tx_data !== 8'(8'h30 + n))
                        $display("FAIL tx_byte_%0d: got %h want %h", n, bus.tx_data,
                                 8'(8'h30 + n));
                    else pass_cnt++;
                end
                n++;
            end
            @(posedge eclk);
            #1;
        end
        total_cnt++;
        if (n !== 16) $display("FAIL tx_pulse_count: got %0d want 16", n);
        else pass_cnt++;
        total_cnt++;
        if (min_gap < TxGuard) $display("FAIL tx_guard_gap: got %0d want >= %0d", min_gap, TxGuard);
        else pass_cnt++;
        cpu_read(SelDspcr, v);
        total_cnt++;
        if (v !== 8'h80) $display("FAIL tx_dspcr_drained: got %h want 80", v);
        else pass_cnt++;
    endtask

    task automatic test_rx_backpressure();
        logic [7:0] v;
        bit ok, all_ok, seen;
        all_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            uart_send(8'(8'h50 + i), ok);
            if (!ok) all_ok = 1'b0;
        end
        total_cnt++;
        if (!all_ok) $display("FAIL bp_fill: an rx_ack was missing");
        else pass_cnt++;
        bus.rx_data = 8'h7e;
        bus.rx_flag = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 if (bus.rx_ack) seen = 1'b1;
            @(posedge eclk);
            #1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL bp_no_ack: rx_ack while full, want none");
        else pass_cnt++;
        cpu_read(SelKbd, v);
        total_cnt++;
        if (v !== 8'hD0) $display("FAIL bp_first_read: got %h want D0", v);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (bus.rx_ack !== 1'b1) $display("FAIL bp_ack_after_pop: got %b want 1", bus.rx_ack);
        else pass_cnt++;
        @(posedge eclk);
        #1 bus.rx_flag = 1'b0;
        @(posedge eclk);
        #1;
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp;
            exp = (i == 16) ? 8'hFE : 8'(8'hD0 + i);
            cpu_read(SelKbd, v);
            total_cnt++;
            if (v !== exp) $display("FAIL bp_read_%0d: got %h want %h", i, v, exp);
            else pass_cnt++;
        end
        cpu_read(SelKbdcr, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL bp_kbdcr_empty: got %h want 00", v);
        else pass_cnt++;
    endtask

    task automatic test_upcase_reset();
        logic [7:0] v, exp;
        bit ok;
`ifdef PIA_FIFO_UPCASE_EN
        exp = 8'hC1;
`else
        exp = 8'hE1;
`endif
        uart_send(8'h61, ok);
        total_cnt++;
        if (!ok) $display("FAIL up_send: no rx_ack within budget");
        else pass_cnt++;
        cpu_read(SelKbd, v);
        total_cnt++;
        if (v !== exp) $display("FAIL up_kbd: got %h want %h", v, exp);
        else pass_cnt++;
        uart_send(8'h42, ok);
        // Two back-to-back DSP writes: the second coincides with the first pop.
        bus.tx_flag = 1'b1;
        bus.reg_sel = SelDsp;
        bus.din = 8'h55;
        bus.wr = 1'b1;
        @(posedge eclk);
        #1 bus.din = 8'h56;
        #1;
        total_cnt++;
        if (bus.tx_wr !== 1'b0) $display("FAIL lat_cycle1: tx_wr=%b want 0", bus.tx_wr);
        else pass_cnt++;
        @(posedge eclk);
        #1 bus.wr = 1'b0;
        bus.reg_sel = SelDspcr;
        #1;
        total_cnt++;
        if (bus.tx_wr !== 1'b1 || bus.tx_data !== 8'h55)
            $display("FAIL lat_cycle2: tx_wr=%b data=%h want 1 55", bus.tx_wr, bus.tx_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.dout !== 8'h01) $display("FAIL push_pop_count: dspcr=%h want 01", bus.dout);
        else pass_cnt++;
        // Reset in the middle of the LOAD cycle.
        #1 ereset = 1'b1;
        #1;
        total_cnt++;
        if (bus.tx_wr !== 1'b0 || bus.tx_data !== 8'h00)
            $display("FAIL rst_load: tx_wr=%b data=%h want 0 00", bus.tx_wr, bus.tx_data);
        else pass_cnt++;
        @(posedge eclk);
        #1 ereset = 1'b0;
        cpu_read(SelDspcr, v);
        total_cnt++;
        if (v !== 8'h80) $display("FAIL rst_dspcr: got %h want 80", v);
        else pass_cnt++;
        cpu_read(SelKbdcr, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL rst_kbdcr: got %h want 00", v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx_overflow();
        test_tx_drain();
        test_rx_backpressure();
        test_upcase_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
